// File: rtl/id_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// id_hazard_scoreboard
//
// Register-dependency scoreboard and interlock controller for the decode stage.
// Each architectural register 1..31 has a 2-bit count of issued instructions
// that still owe a register-file write. The instruction in ID is stalled while
// any register it reads has a nonzero count. A drain request stalls issue until
// every count is zero, then pulses Drained_out for one cycle.
//
// Ports:
//   Clk_in            clock, rising edge
//   Reset_in          asynchronous active-high reset
//   Instruction_ID    instruction in ID (rs=[25:21], rt=[20:16], rd=[15:11])
//   Valid_ID          ID holds a real instruction
//   Use_rs_ID/Use_rt_ID  instruction reads rs / rt
//   RegWrite_ID       instruction writes a register
//   RegDst_ID         destination is rd (1) or rt (0)
//   JAL_ID            destination forced to register 31
//   Flush_in          kill the ID instruction this cycle (blocks issue only)
//   RegWrite_WB       register-file write this cycle
//   WriteRegister_WB  register being written back
//   Drain_in          drain request pulse (honoured only in RUN)
//   Stall_out         hold PC and IF/ID, insert bubble into ID/EX
//   Pending_out       bit i set when register i has a nonzero count
//   Drained_out       one-cycle pulse when the drain completes
//   Error_out         sticky count overflow/underflow flag
//   StallCount_out    (only with ID_SCOREBOARD_STALLCNT_EN) saturating count
//                     of RUN cycles with Stall_out asserted
//
// Build option: define ID_SCOREBOARD_STALLCNT_EN to add StallCount_out.
// -----------------------------------------------------------------------------
module id_hazard_scoreboard (
    input  logic        Clk_in,
    input  logic        Reset_in,
    input  logic [31:0] Instruction_ID,
    input  logic        Valid_ID,
    input  logic        Use_rs_ID,
    input  logic        Use_rt_ID,
    input  logic        RegWrite_ID,
    input  logic        RegDst_ID,
    input  logic        JAL_ID,
    input  logic        Flush_in,
    input  logic        RegWrite_WB,
    input  logic [4:0]  WriteRegister_WB,
    input  logic        Drain_in,
    output logic        Stall_out,
    output logic [31:0] Pending_out,
    output logic        Drained_out,
    output logic        Error_out
`ifdef ID_SCOREBOARD_STALLCNT_EN
    ,
    output logic [31:0] StallCount_out
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state, state_next;
    logic [1:0]  cnt      [32];
    logic [1:0]  cnt_next [32];
    logic [4:0]  rs, rt, rd, dst;
    logic        hazard, issue, retire, all_zero, err_event;
    logic [31:0] inc_vec, dec_vec;

    assign rs  = Instruction_ID[25:21];
    assign rt  = Instruction_ID[20:16];
    assign rd  = Instruction_ID[15:11];
    assign dst = JAL_ID ? 5'd31 : (RegDst_ID ? rd : rt);

    // Register 0 is never tracked, so its pending bit is tied low.
    always_comb begin
        Pending_out[0] = 1'b0;
        for (int i = 1; i < 32; i++) begin
            Pending_out[i] = (cnt[i] != 2'd0);
        end
    end

    assign all_zero = ~|Pending_out;

    // Uses registered counts only: a writeback in this cycle does not release
    // the stall until the following cycle.
    assign hazard = Valid_ID &
                    ((Use_rs_ID & (rs != 5'd0) & Pending_out[rs]) |
                     (Use_rt_ID & (rt != 5'd0) & Pending_out[rt]));

    // FSM next-state and outputs.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        Stall_out   = hazard;
        Drained_out = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (Drain_in) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                Stall_out = 1'b1;
                if (all_zero) state_next = ST_DONE;
            end
            ST_DONE: begin
                Stall_out   = 1'b1;
                Drained_out = 1'b1;
                state_next  = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Stall_out already covers DRAIN/DONE, so no issue happens while draining.
    assign issue  = Valid_ID & RegWrite_ID & ~Stall_out & ~Flush_in & (dst != 5'd0);
    assign retire = RegWrite_WB & (WriteRegister_WB != 5'd0);

    assign inc_vec = issue  ? (32'd1 << dst)              : 32'd0;
    assign dec_vec = retire ? (32'd1 << WriteRegister_WB) : 32'd0;

    // Per-register count update. Simultaneous issue and retire cancel out;
    // over/underflow holds the count and raises the error flag.
    always_comb begin
        err_event   = 1'b0;
        cnt_next[0] = 2'd0;
        for (int i = 1; i < 32; i++) begin
            cnt_next[i] = cnt[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                if (cnt[i] == 2'd3) err_event = 1'b1;
                else                cnt_next[i] = cnt[i] + 2'd1;
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt[i] == 2'd0) err_event = 1'b1;
                else                cnt_next[i] = cnt[i] - 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the count array is real state that must start at zero, so it is
    // reset explicitly rather than treated as an uninitialised memory.
    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            state     <= ST_RUN;
            Error_out <= 1'b0;
            for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
        end else begin
            state <= state_next;
            if (err_event) Error_out <= 1'b1;
            for (int i = 0; i < 32; i++) cnt[i] <= cnt_next[i];
        end
    end

`ifdef ID_SCOREBOARD_STALLCNT_EN
    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            StallCount_out <= 32'd0;
        end else if ((state == ST_RUN) && Stall_out && (StallCount_out != 32'hFFFF_FFFF)) begin
            StallCount_out <= StallCount_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;

    logic        Clk_in = 1'b0;
    logic        Reset_in;
    logic [31:0] Instruction_ID;
    logic        Valid_ID, Use_rs_ID, Use_rt_ID, RegWrite_ID, RegDst_ID, JAL_ID, Flush_in;
    logic        RegWrite_WB;
    logic [4:0]  WriteRegister_WB;
    logic        Drain_in;
    logic        Stall_out;
    logic [31:0] Pending_out;
    logic        Drained_out;
    logic        Error_out;
`ifdef ID_SCOREBOARD_STALLCNT_EN
    logic [31:0] StallCount_out;
`endif

    id_hazard_scoreboard dut (
        .Clk_in           (Clk_in),
        .Reset_in         (Reset_in),
        .Instruction_ID   (Instruction_ID),
        .Valid_ID         (Valid_ID),
        .Use_rs_ID        (Use_rs_ID),
        .Use_rt_ID        (Use_rt_ID),
        .RegWrite_ID      (RegWrite_ID),
        .RegDst_ID        (RegDst_ID),
        .JAL_ID           (JAL_ID),
        .Flush_in         (Flush_in),
        .RegWrite_WB      (RegWrite_WB),
        .WriteRegister_WB (WriteRegister_WB),
        .Drain_in         (Drain_in),
        .Stall_out        (Stall_out),
        .Pending_out      (Pending_out),
        .Drained_out      (Drained_out),
        .Error_out        (Error_out)
`ifdef ID_SCOREBOARD_STALLCNT_EN
        ,
        .StallCount_out   (StallCount_out)
`endif
    );

    always #5 Clk_in = ~Clk_in;

    typedef struct {
        logic        valid, use_rs, use_rt, regwrite, regdst, jal, flush;
        logic [4:0]  rs, rt, rd;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic        drain;
        logic        exp_stall;
        logic [31:0] exp_pend;
        logic        exp_drained, exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic valid, use_rs, input logic [4:0] rs,
        input logic use_rt, input logic [4:0] rt,
        input logic regwrite, regdst, jal, input logic [4:0] rd,
        input logic flush, wb_we, input logic [4:0] wb_reg, input logic drain,
        input logic exp_stall, input logic [31:0] exp_pend,
        input logic exp_drained, exp_err);
        vec_t v;
        v.valid = valid; v.use_rs = use_rs; v.rs = rs; v.use_rt = use_rt; v.rt = rt;
        v.regwrite = regwrite; v.regdst = regdst; v.jal = jal; v.rd = rd;
        v.flush = flush; v.wb_we = wb_we; v.wb_reg = wb_reg; v.drain = drain;
        v.exp_stall = exp_stall; v.exp_pend = exp_pend;
        v.exp_drained = exp_drained; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Valid_ID         = v.valid;
        Use_rs_ID        = v.use_rs;
        Use_rt_ID        = v.use_rt;
        RegWrite_ID      = v.regwrite;
        RegDst_ID        = v.regdst;
        JAL_ID           = v.jal;
        Flush_in         = v.flush;
        Instruction_ID   = {6'd0, v.rs, v.rt, v.rd, 11'd0};
        RegWrite_WB      = v.wb_we;
        WriteRegister_WB = v.wb_reg;
        Drain_in         = v.drain;
    endtask

    // Drive one cycle's inputs, check outputs on the falling edge, then let
    // the rising edge commit the cycle.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        @(negedge Clk_in);
        check({tag, " stall"},   {31'd0, Stall_out},   {31'd0, v.exp_stall});
        check({tag, " pending"}, Pending_out,          v.exp_pend);
        check({tag, " drained"}, {31'd0, Drained_out}, {31'd0, v.exp_drained});
        check({tag, " error"},   {31'd0, Error_out},   {31'd0, v.exp_err});
        @(posedge Clk_in);
        #1;
    endtask

    // Field order for mk():
    // valid use_rs rs use_rt rt regwrite regdst jal rd flush wb_we wb_reg drain | stall pend drained err
    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0, 0,  0,32'h0,0,0);

        // Add $3 then a dependent reader of $3.
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(1,1,1, 0,0, 1,1,0,3,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(1,1,3, 0,0, 0,0,0,0,  0, 0,0, 0,  1,32'h8,       0,0));
        vecs.push_back(mk(1,1,3, 0,0, 0,0,0,0,  0, 1,3, 0,  1,32'h8,       0,0));
        vecs.push_back(mk(1,1,3, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // JAL to $31, reader of rt=31, then a write to $0 that must not track.
        vecs.push_back(mk(1,0,0, 0,0, 1,0,1,0,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(1,0,0, 1,31,0,0,0,0,  0, 0,0, 0,  1,32'h8000_0000,0,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,0,0,0,  0, 0,0, 0,  0,32'h8000_0000,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 1,31,0,  0,32'h8000_0000,0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // Same-cycle issue and retire on $5 with count 1.
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,5,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,5,  0, 1,5, 0,  0,32'h20,      0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h20,      0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 1,5, 0,  0,32'h20,      0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // Flushed write to $4 never issues.
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,4,  1, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // Flush does not suppress a stall on $6.
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,6,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(1,1,6, 0,0, 1,1,0,6,  1, 0,0, 0,  1,32'h40,      0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 1,6, 0,  0,32'h40,      0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // Invalid ID never stalls; rt dependency stalls despite same-cycle retire.
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,2,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(0,1,2, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h4,       0,0));
        vecs.push_back(mk(1,0,0, 1,2, 0,0,0,0,  0, 1,2, 0,  1,32'h4,       0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // Drain with $8 and $9 in flight; write to $10 during drain is held off.
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,8,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,9,  0, 0,0, 0,  0,32'h100,     0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 1,  0,32'h300,     0,0));
        vecs.push_back(mk(1,0,0, 0,0, 1,1,0,10, 0, 0,0, 0,  1,32'h300,     0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 1,8, 0,  1,32'h300,     0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 1,9, 0,  1,32'h200,     0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  1,32'h0,       0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 1,  1,32'h0,       1,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));
        // Drain when already empty: DRAIN, DONE, RUN.
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 1,  0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  1,32'h0,       0,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  1,32'h0,       1,0));
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0,0,  0, 0,0, 0,  0,32'h0,       0,0));

        // Reset and reset-state checks.
        drive(idle);
        Reset_in = 1'b1;
        repeat (2) @(posedge Clk_in);
        #1 Reset_in = 1'b0;
        @(negedge Clk_in);
        check("reset stall",   {31'd0, Stall_out},   32'd0);
        check("reset pending", Pending_out,          32'd0);
        check("reset drained", {31'd0, Drained_out}, 32'd0);
        check("reset error",   {31'd0, Error_out},   32'd0);
        @(posedge Clk_in);
        #1;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Overflow on $7: count saturates at 3, so three retires are needed.
        run_vec("ovf1", mk(1,0,0, 0,0, 1,1,0,7, 0, 0,0, 0,  0,32'h0,  0,0));
        run_vec("ovf2", mk(1,0,0, 0,0, 1,1,0,7, 0, 0,0, 0,  0,32'h80, 0,0));
        run_vec("ovf3", mk(1,0,0, 0,0, 1,1,0,7, 0, 0,0, 0,  0,32'h80, 0,0));
        run_vec("ovf4", mk(1,0,0, 0,0, 1,1,0,7, 0, 0,0, 0,  0,32'h80, 0,0));
        run_vec("ovf5", mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0, 0,  0,32'h80, 0,1));
        run_vec("ovf6", mk(0,0,0, 0,0, 0,0,0,0, 0, 1,7, 0,  0,32'h80, 0,1));
        run_vec("ovf7", mk(0,0,0, 0,0, 0,0,0,0, 0, 1,7, 0,  0,32'h80, 0,1));
        run_vec("ovf8", mk(0,0,0, 0,0, 0,0,0,0, 0, 1,7, 0,  0,32'h80, 0,1));
        run_vec("ovf9", mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0, 0,  0,32'h0,  0,1));

        // Reset clears the sticky error.
        Reset_in = 1'b1;
        #2;
        check("rst2 error", {31'd0, Error_out}, 32'd0);
        @(negedge Clk_in);
        Reset_in = 1'b0;
        @(posedge Clk_in);
        #1;

        // Underflow on $9.
        run_vec("udf1", mk(0,0,0, 0,0, 0,0,0,0, 0, 1,9, 0,  0,32'h0, 0,0));
        run_vec("udf2", mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0, 0,  0,32'h0, 0,1));

        // Reset in the middle of a drain with $3 outstanding.
        run_vec("rd1", mk(1,0,0, 0,0, 1,1,0,3, 0, 0,0, 0,  0,32'h0, 0,1));
        run_vec("rd2", mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0, 1,  0,32'h8, 0,1));
        run_vec("rd3", mk(1,1,3, 0,0, 0,0,0,0, 0, 0,0, 0,  1,32'h8, 0,1));
        #2 Reset_in = 1'b1;
        #1;
        check("rd stall",   {31'd0, Stall_out},   32'd0);
        check("rd pending", Pending_out,          32'd0);
        check("rd drained", {31'd0, Drained_out}, 32'd0);
        check("rd error",   {31'd0, Error_out},   32'd0);
        @(negedge Clk_in);
        Reset_in = 1'b0;
        @(posedge Clk_in);
        #1;
        // Late writeback of $3 retires into a zero count.
        run_vec("rd4", mk(1,1,3, 0,0, 0,0,0,0, 0, 1,3, 0,  0,32'h0, 0,0));
        run_vec("rd5", mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0, 0,  0,32'h0, 0,1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Register-dependency scoreboard and interlock controller for the decode stage. Tracks, per architectural register, how many issued instructions still owe a register-file write, and stalls the instruction in ID while any source it reads is pending. Also sequences a pipeline drain on request. Sits beside the decode stage: it consumes the ID instruction and decoded controls plus the writeback port, and drives PC/IF-ID hold and ID/EX bubble insertion.

## Interface
- No parameters.
- Clk_in  input  1  clock; all state updates on rising edge.
- Reset_in  input  1  reset, asynchronous, active-high.
- Instruction_ID  input  32  instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11].
- Valid_ID  input  1  ID holds a real instruction.
- Use_rs_ID, Use_rt_ID  input  1 each  instruction reads rs / rt.
- RegWrite_ID  input  1  instruction writes a register.
- RegDst_ID  input  1  destination is rd (1) or rt (0).
- JAL_ID  input  1  destination forced to 31.
- Flush_in  input  1  kill the ID instruction this cycle.
- RegWrite_WB  input  1  register-file write this cycle.
- WriteRegister_WB  input  5  register written.
- Drain_in  input  1  request full drain (pulse).
- Stall_out  output  1  hold PC and IF/ID; insert bubble into ID/EX.
- Pending_out  output  32  bit i = register i has count != 0; bit 0 always 0.
- Drained_out  output  1  one-cycle pulse: drain complete.
- Error_out  output  1  sticky counter over/underflow flag.

## Operation
- Destination dst = 31 if JAL_ID, else rd if RegDst_ID, else rt.
- 31 counters cnt[1..31], 2 bits each; register 0 never tracked.
- Issue = Valid_ID & RegWrite_ID & !Stall_out & !Flush_in & dst != 0 → cnt[dst]+1.
- Retire = RegWrite_WB & WriteRegister_WB != 0 → cnt[WriteRegister_WB]-1.
- Issue and retire on the same register in one cycle: count unchanged.
- Overflow (cnt=3, issue, no retire): hold 3, set Error_out. Underflow (cnt=0, retire): hold 0, set Error_out. Error_out clears only on reset.
- Hazard = Valid_ID & ((Use_rs_ID & rs!=0 & cnt[rs]!=0) | (Use_rt_ID & rt!=0 & cnt[rt]!=0)). Uses registered counts only; no same-cycle retire bypass.
- Flush_in does not suppress Stall_out; it only blocks issue.
- FSM states:
  - RUN: Stall_out = Hazard. Drain_in → DRAIN.
  - DRAIN: Stall_out = 1 (no issue). When all counts are 0 → DONE.
  - DONE: Stall_out = 1, Drained_out = 1. Next cycle → RUN.
- Drain_in is ignored outside RUN.
- Retires continue in every state.

## Timing
- Reset values: all counts 0, state RUN, Stall_out follows Hazard (0 with zero counts), Pending_out 0, Drained_out 0, Error_out 0.
- Stall_out is combinational from registered state plus ID inputs. It is valid in the same cycle.
- Issue at edge N sets Pending_out[dst] after edge N. A dependent instruction in ID in cycle N+1 stalls.
- A retire at edge M releases the stall in cycle M+1.
- Drain: Drain_in sampled at edge N → DRAIN from N+1. Minimum latency to Drained_out is 2 cycles if already empty (DRAIN, then DONE).
- Reset asserted mid-drain or mid-stall: immediate return to reset values. In-flight writebacks then retire into zero counts and raise Error_out. Reset is therefore applied pipeline-wide.

## Configuration
- ID_SCOREBOARD_STALLCNT_EN:
  - Defined: adds output StallCount_out (32 bits). It increments every cycle Stall_out=1 while in RUN, saturates at 0xFFFFFFFF, and resets to 0.
  - Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Issue add $3 (RegDst=1, rd=3) at edge 1; next ID instruction reads rs=3 → Stall_out=1 until RegWrite_WB with reg 3 retires, then 0 the following cycle; Pending_out[3] returns to 0.
- JAL issued → Pending_out = 0x80000000; instruction using rt=31 stalls; rt=0 with RegWrite never changes Pending_out.
- Same cycle: issue to $5 while WB retires $5 with cnt[5]=1 → cnt[5] stays 1, Pending_out[5]=1, Error_out=0.
- Four issues to $7 with no retires → cnt holds 3 and Error_out=1 sticky. Retire with cnt[9]=0 → Error_out=1.
- Drain_in with 2 in flight → Stall_out=1 throughout; Drained_out pulses exactly one cycle after the last retire brings all counts to 0, then back to RUN.
- Flush_in with RegWrite_ID=1, dst=4 → no issue, Pending_out[4]=0. Reset mid-DRAIN → state RUN, all outputs at reset values.
